gf16_comp_inv_pipe: RTL
=======================

Name: gf16_comp_inv_pipe

Overview:
Three-stage pipelined multiplicative inverter over the composite field GF((2^4)^2). It sits directly downstream of the GF(2^8)→GF((2^4)^2) isomorphic mapping stage of the AES S-box datapath and feeds the inverse-mapping/affine stage. It has a valid/ready handshake on both sides so the S-box can be shared by the round and key-expansion datapaths.

Parameters:
LAMBDA, 4'hC, constant λ of extension polynomial y^2 + y + λ; GF(2^4) polynomial fixed at x^4 + x + 1.
DATA_W, 8, element width; only 8 is supported, and any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
in_data  input  8  composite-field element; [7:4] = ah (coefficient of y), [3:0] = al.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts out_data.
out_data  output  8  inverse element, same nibble layout; inverse of 0 is 0.
err  output  1  inverse self-check failure; present only with the macro, otherwise tied 0.

Behaviour:
- Reset: one clock, synchronous and active-high (clk, rst). When rst is high at a rising edge, all stage valid flags clear. Output values after reset: out_valid=0, err=0, out_data=8'h00. in_ready=1 from the first cycle after reset. Data registers are also cleared to 0.
- Arithmetic, all in GF(2^4) mod x^4+x+1. Additions are XOR.
  - S1 registers ah, al and d = λ·ah^2 ⊕ ah·al ⊕ al^2.
  - S2 registers ah, al and dinv = d^-1, with 0^-1 = 0.
  - S3 registers out_h = ah·dinv and out_l = (ah ⊕ al)·dinv. out_data = {out_h, out_l}.
- Latency: 3 cycles from accepted input to out_valid when there is no stall. Throughput is 1 element per cycle.
- Handshake:
  - A transfer occurs when valid && ready are both high at a rising edge.
  - Stage k loads when stage k is empty or stage k is advancing. Stage 3 advances when out_ready=1. Stage k<3 advances when stage k+1 loads.
  - in_ready = !v1 || S1 advancing. This is combinational from out_ready through the chain; it is not registered.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Full pipeline with out_ready=0: in_ready deasserts in the same cycle, and no data is lost or duplicated.
- Simultaneous input accept and output pop on a full pipeline: both occur, and occupancy stays at 3.
- Bubbles: an empty middle stage is filled even while stage 3 is stalled.
- Reset mid-operation: all in-flight data is discarded and no out_valid pulse appears after reset. in_valid is ignored during a reset cycle.
- No combinational path from in_data to out_data.

Optional Feature:
Macro GF16_INV_SELFCHECK_EN.
- Defined:
  - S3 also registers a copy of the input element.
  - err = out_valid && (x ≠ 0) && (x·x^-1 ≠ 8'h01), with the product computed in GF((2^4)^2) using λ.
  - err also fires when x = 0 and out_data ≠ 0.
  - err holds while stalled, and is cleared by rst.
  - Used for fault-injection detection.
- Not defined: err tied to 0, no extra registers, identical data timing.

Test Plan:
- Reset/idle: hold rst 2 cycles with in_valid=1 → out_valid=0, out_data=8'h00, in_ready=1 after release, no spurious output.
- Single inverse: in_data=8'h02 accepted at cycle t, out_ready=1 → out_valid at t+3 with out_data=8'h09. Also 8'h01→8'h01 and 8'h00→8'h00.
- Streaming: all 256 values back-to-back, out_ready=1 → 256 outputs in order, one per cycle. Each nonzero result × input = 8'h01 per the reference model. Inverse-of-inverse returns the original value.
- Backpressure: stream 5 values, drop out_ready for 4 cycles after the first output → in_ready low once 3 are held, out_data stable, all 5 delivered in order, none lost or duplicated.
- Reset mid-stream: 2 elements in flight, assert rst 1 cycle → no out_valid afterwards. A new input 8'h02 yields 8'h09 after 3 cycles.
- Self-check (macro defined): force S3 out_l bit 0 flipped for input 8'h02 → err=1 coincident with out_valid. Unforced run of all 256 values → err never asserted.

Source files
------------

// File: rtl/gf16_comp_inv_pipe.sv
// Three-stage valid/ready pipelined inverter over GF((2^4)^2), y^2 + y + LAMBDA, GF(2^4) mod x^4+x+1.
// Define GF16_INV_SELFCHECK_EN to add the x * x^-1 == 1 output check on err.
module gf16_comp_inv_pipe #(
    parameter logic [3:0] LAMBDA = 4'hC,
    parameter int         DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    if (DATA_W != 8) begin : g_bad_width
        $error("gf16_comp_inv_pipe: DATA_W must be 8");
    end

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0 naturally.
    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] a2;
        logic [3:0] a4;
        logic [3:0] a8;
        a2 = gf_mul(a, a);
        a4 = gf_mul(a2, a2);
        a8 = gf_mul(a4, a4);
        return gf_mul(gf_mul(a2, a4), a8);
    endfunction

    logic [3:0] w_ah0;
    logic [3:0] w_al0;
    logic [3:0] w_d0;
    logic       w_ld1;
    logic       w_ld2;
    logic       w_ld3;

    logic       r_v1;
    logic [3:0] r_ah1;
    logic [3:0] r_al1;
    logic [3:0] r_d1;
    logic       r_v2;
    logic [3:0] r_ah2;
    logic [3:0] r_al2;
    logic [3:0] r_dinv2;
    logic       r_v3;
    logic [3:0] r_out_h;
    logic [3:0] r_out_l;

    assign w_ah0 = in_data[7:4];
    assign w_al0 = in_data[3:0];
    assign w_d0  = gf_mul(gf_mul(LAMBDA, w_ah0), w_ah0) ^ gf_mul(w_ah0, w_al0) ^ gf_mul(w_al0, w_al0);

    // Each stage loads when empty or when its contents move on; chain is combinational from out_ready.
    assign w_ld3    = !r_v3 || out_ready;
    assign w_ld2    = !r_v2 || w_ld3;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;

`ifdef GF16_INV_SELFCHECK_EN
    logic [7:0] r_x3;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_ah1   <= 4'h0;
            r_al1   <= 4'h0;
            r_d1    <= 4'h0;
            r_v2    <= 1'b0;
            r_ah2   <= 4'h0;
            r_al2   <= 4'h0;
            r_dinv2 <= 4'h0;
            r_v3    <= 1'b0;
            r_out_h <= 4'h0;
            r_out_l <= 4'h0;
`ifdef GF16_INV_SELFCHECK_EN
            r_x3    <= 8'h00;
`endif
        end else begin
            if (w_ld1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_ah1 <= w_ah0;
                    r_al1 <= w_al0;
                    r_d1  <= w_d0;
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_ah2   <= r_ah1;
                    r_al2   <= r_al1;
                    r_dinv2 <= gf_inv(r_d1);
                end
            end
            // Data only moves with a valid token, so a stalled output holds steady.
            if (w_ld3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_out_h <= gf_mul(r_ah2, r_dinv2);
                    r_out_l <= gf_mul(r_ah2 ^ r_al2, r_dinv2);
`ifdef GF16_INV_SELFCHECK_EN
                    r_x3    <= {r_ah2, r_al2};
`endif
                end
            end
        end
    end

    assign out_valid = r_v3;
    assign out_data  = {r_out_h, r_out_l};

`ifdef GF16_INV_SELFCHECK_EN
    // (ah y + al)(bh y + bl) with y^2 = y + LAMBDA.
    function automatic logic [7:0] cf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf_mul(a[7:4], b[7:4]);
        return {hh ^ gf_mul(a[7:4], b[3:0]) ^ gf_mul(a[3:0], b[7:4]),
                gf_mul(hh, LAMBDA) ^ gf_mul(a[3:0], b[3:0])};
    endfunction

    logic [7:0] w_prod;
    assign w_prod = cf_mul(r_x3, {r_out_h, r_out_l});
    assign err    = r_v3 && (((r_x3 != 8'h00) && (w_prod != 8'h01)) ||
                             ((r_x3 == 8'h00) && ({r_out_h, r_out_l} != 8'h00)));
`else
    assign err = 1'b0;
`endif

endmodule
